// File: rtl/dot_product_accumulator.sv
// dot_product_accumulator
// Sums VEC_LEN unsigned products into one dot-product and presents each
// finished sum on a valid/ready port. The result is registered, so no
// combinational path runs from prod to acc_data.
//
// Build option: define DOT_ACC_DBUF_EN for overlap mode. In that mode the
// next vector accumulates while the previous result is still being held.
// When the macro is undefined, input is stalled until the result is taken.
module dot_product_accumulator #(
  parameter int PROD_W  = 16,
  parameter int VEC_LEN = 8,
  parameter int ACC_W   = PROD_W + $clog2(VEC_LEN),
  parameter int CNT_W   = $clog2(VEC_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  acc_data,
  output logic [CNT_W-1:0]  term_cnt
);

  typedef enum logic {ACCUM, DONE} state_t;

  state_t           state_reg;
  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] acc_sum;
  logic             accept;
  logic             take;
  logic             last_term;

  assign accept    = prod_valid & prod_ready;
  assign take      = acc_valid & acc_ready;
  assign last_term = (term_cnt == CNT_W'(VEC_LEN - 1));

  // Running sum including the offered product. This value is only used
  // under accept, so an undefined prod on idle cycles never reaches acc.
  assign acc_sum = acc_reg + ACC_W'(prod);

`ifdef DOT_ACC_DBUF_EN
  // The final term may enter only when the held result leaves in the same
  // cycle. This keeps one product per cycle while the consumer keeps up.
  assign prod_ready = !(last_term && acc_valid && !acc_ready);

  // Accumulator and result FSM for overlap mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ACCUM;
      acc_reg   <= '0;
      term_cnt  <= '0;
      acc_valid <= 1'b0;
      acc_data  <= '0;
    end else if (clear) begin
      state_reg <= ACCUM;
      acc_reg   <= '0;
      term_cnt  <= '0;
      acc_valid <= 1'b0;
    end else begin
      case (state_reg)
        ACCUM: begin
          if (accept) begin
            if (last_term) begin
              acc_data  <= acc_sum;
              acc_valid <= 1'b1;
              acc_reg   <= '0;
              term_cnt  <= '0;
              state_reg <= DONE;
            end else begin
              acc_reg  <= acc_sum;
              term_cnt <= term_cnt + CNT_W'(1);
            end
          end
        end
        DONE: begin
          if (accept && last_term) begin
            // The old result is taken in this same cycle, and the new
            // result replaces it. acc_valid therefore stays high.
            acc_data <= acc_sum;
            acc_reg  <= '0;
            term_cnt <= '0;
          end else begin
            if (accept) begin
              acc_reg  <= acc_sum;
              term_cnt <= term_cnt + CNT_W'(1);
            end
            if (take) begin
              acc_valid <= 1'b0;
              state_reg <= ACCUM;
            end
          end
        end
        default: state_reg <= ACCUM;
      endcase
    end
  end
`else
  logic prod_ready_reg;

  assign prod_ready = prod_ready_reg;

  // Accumulator and result FSM for single-buffer mode. Input is stalled
  // while a result is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ACCUM;
      acc_reg        <= '0;
      term_cnt       <= '0;
      acc_valid      <= 1'b0;
      acc_data       <= '0;
      prod_ready_reg <= 1'b1;
    end else if (clear) begin
      state_reg      <= ACCUM;
      acc_reg        <= '0;
      term_cnt       <= '0;
      acc_valid      <= 1'b0;
      prod_ready_reg <= 1'b1;
    end else begin
      case (state_reg)
        ACCUM: begin
          if (accept) begin
            if (last_term) begin
              acc_data       <= acc_sum;
              acc_valid      <= 1'b1;
              acc_reg        <= '0;
              term_cnt       <= '0;
              prod_ready_reg <= 1'b0;
              state_reg      <= DONE;
            end else begin
              acc_reg  <= acc_sum;
              term_cnt <= term_cnt + CNT_W'(1);
            end
          end
        end
        DONE: begin
          if (take) begin
            acc_valid      <= 1'b0;
            prod_ready_reg <= 1'b1;
            state_reg      <= ACCUM;
          end
        end
        default: state_reg <= ACCUM;
      endcase
    end
  end
`endif

endmodule
